// File: rtl/ser_pkg.sv
// Shared types for the serial word feeder: FSM state encoding, direction codes,
// and a counter-width helper.
package ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    DONE   = 3'd3,
    GAP    = 3'd4
  } ser_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Width able to hold 0..limit, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Clear/increment counter flagging its LIMIT-1 value; used for both the shift-bit
// count and the post-frame gap count.
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int unsigned W = cnt_width(LIMIT);
  localparam logic [W-1:0] LAST_VAL = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign last = (r_cnt == LAST_VAL);

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for a bidirectional shift register: one word per
// valid/ready handshake, one bit per clock. Optional even-parity bit: SER_PARITY_EN.
//
// Handshake: a word is accepted on a rising clk edge where in_valid && in_ready;
// in_ready is high only in IDLE and outside reset, and upstream must hold
// in_valid/in_data/in_dir stable until that edge.
module serial_word_feeder
  import ser_pkg::*;
#(
  parameter int unsigned MSB      = 4,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  output logic           sr_d,
  output logic           sr_en,
  output logic           sr_dir,
  output logic           frame_done,
  output logic           busy,
  output ser_state_t     o_dbg_state
);

  localparam int unsigned GAP_LIMIT = (IDLE_GAP > 0) ? IDLE_GAP : 1;

  ser_state_t     r_state;
  ser_state_t     w_next;
  logic [MSB-1:0] r_work;
  logic [MSB-1:0] w_work_nxt;
  logic           r_sr_d;
  logic           r_sr_en;
  logic           r_sr_dir;
  logic           r_frame_done;
  logic           r_busy;
  logic           w_sr_d_nxt;
  logic           w_sr_en_nxt;
  logic           w_sr_dir_nxt;
  logic           w_accept;
  logic           w_bit_last;
  logic           w_gap_last;
`ifdef SER_PARITY_EN
  logic [MSB-1:0] r_shadow;
`endif

  assign in_ready    = (r_state == IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign o_dbg_state = r_state;

  ser_bit_counter #(.LIMIT(MSB)) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .inc  (r_state == SHIFT),
    .last (w_bit_last)
  );

  ser_bit_counter #(.LIMIT(GAP_LIMIT)) u_gap_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state == DONE),
    .inc  (r_state == GAP),
    .last (w_gap_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next = SHIFT;
`ifdef SER_PARITY_EN
      SHIFT:  if (w_bit_last) w_next = PARITY;
      PARITY: w_next = DONE;
`else
      SHIFT:  if (w_bit_last) w_next = DONE;
`endif
      DONE:   w_next = (IDLE_GAP > 0) ? GAP : IDLE;
      GAP:    if (w_gap_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from w_next. r_work
  // always holds the not-yet-sent bits aligned so the next one sits at the send end.
  always_comb begin
    w_sr_dir_nxt = r_sr_dir;
    w_work_nxt   = r_work;
    w_sr_d_nxt   = 1'b0;
    w_sr_en_nxt  = (w_next == SHIFT);
`ifdef SER_PARITY_EN
    w_sr_en_nxt  = w_sr_en_nxt || (w_next == PARITY);
`endif
    if (w_accept) begin
      w_sr_dir_nxt = in_dir;
      w_sr_d_nxt   = (in_dir == DIR_RIGHT) ? in_data[0] : in_data[MSB-1];
      w_work_nxt   = (in_dir == DIR_RIGHT) ? (in_data >> 1) : (in_data << 1);
    end else if (w_next == SHIFT) begin
      w_sr_d_nxt   = (r_sr_dir == DIR_RIGHT) ? r_work[0] : r_work[MSB-1];
      w_work_nxt   = (r_sr_dir == DIR_RIGHT) ? (r_work >> 1) : (r_work << 1);
    end
`ifdef SER_PARITY_EN
    else if (w_next == PARITY) begin
      w_sr_d_nxt   = ^r_shadow;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work       <= '0;
      r_sr_d       <= 1'b0;
      r_sr_en      <= 1'b0;
      r_sr_dir     <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_work       <= w_work_nxt;
      r_sr_d       <= w_sr_d_nxt;
      r_sr_en      <= w_sr_en_nxt;
      r_sr_dir     <= w_sr_dir_nxt;
      r_frame_done <= (w_next == DONE);
      r_busy       <= (w_next != IDLE);
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_accept) begin
      r_shadow <= in_data;
    end
  end
`endif

  assign sr_d       = r_sr_d;
  assign sr_en      = r_sr_en;
  assign sr_dir     = r_sr_dir;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder (MSB=4): vector table, held-valid, gap, and mid-frame
// reset sequences, scored against a downstream shift-register model.
`timescale 1ns/1ps
module tb_serial_word_feeder;
  import ser_pkg::*;

  localparam int MSB = 4;
`ifdef SER_PARITY_EN
  localparam int NB = MSB + 1;
`else
  localparam int NB = MSB;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           in_valid, in_ready, in_dir;
  logic [MSB-1:0] in_data;
  logic           sr_d, sr_en, sr_dir, frame_done, busy;
  ser_state_t     dbg_state;

  logic           g_valid, g_ready, g_dir;
  logic [MSB-1:0] g_data;
  logic           g_sr_d, g_sr_en, g_sr_dir, g_frame_done, g_busy;
  ser_state_t     g_state;

  serial_word_feeder #(.MSB(MSB), .IDLE_GAP(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .sr_d(sr_d), .sr_en(sr_en),
    .sr_dir(sr_dir), .frame_done(frame_done), .busy(busy), .o_dbg_state(dbg_state)
  );

  serial_word_feeder #(.MSB(MSB), .IDLE_GAP(3)) dut_gap (
    .clk(clk), .rst(rst), .in_valid(g_valid), .in_ready(g_ready),
    .in_data(g_data), .in_dir(g_dir), .sr_d(g_sr_d), .sr_en(g_sr_en),
    .sr_dir(g_sr_dir), .frame_done(g_frame_done), .busy(g_busy), .o_dbg_state(g_state)
  );

  // Downstream bidirectional shift register: dir=0 shifts left (new bit at LSB),
  // dir=1 shifts right (new bit at MSB).
  logic [NB-1:0] down_q = '0;
  always @(posedge clk) begin
    if (sr_en) down_q <= (sr_dir == 1'b0) ? {down_q[NB-2:0], sr_d} : {sr_d, down_q[NB-1:1]};
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [NB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) begin
      if (exp_q.size() == 0) check("frame_unexpected", frame_done, 0);
      else check("frame_word", down_q, exp_q.pop_front());
    end
  end

  function automatic logic [NB-1:0] exp_word(input logic [MSB-1:0] d, input logic dir);
    logic [NB-1:0] w;
`ifdef SER_PARITY_EN
    w = dir ? {^d, d} : {d, ^d};
`else
    w = d;
    if (dir !== 1'b0 && dir !== 1'b1) w = 'x;
`endif
    return w;
  endfunction

  function automatic logic [MSB-1:0] rev(input logic [MSB-1:0] d);
    logic [MSB-1:0] r;
    for (int i = 0; i < MSB; i++) r[i] = d[MSB-1-i];
    return r;
  endfunction

  // ---------------- driver ----------------
  // base: expected serial data bits, first-sent bit in the MSB position.
  task automatic send_word(input logic [MSB-1:0] d, input logic dir,
                           input logic [MSB-1:0] base, input string tag);
    logic [NB-1:0] s;
    int waited;
`ifdef SER_PARITY_EN
    s = {base, ^d};
`else
    s = base;
`endif
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_dir = dir;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, in_ready, 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_word(d, dir));
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d; in_dir = ~dir;
    for (int i = 0; i < NB; i++) begin
      check({tag, "_en"}, sr_en, 1);
      check({tag, "_d"}, sr_d, s[NB-1-i]);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_rdy_low"}, in_ready, 0);
      @(negedge clk);
    end
    check({tag, "_done"}, frame_done, 1);
    check({tag, "_en_off"}, sr_en, 0);
    check({tag, "_dir"}, sr_dir, dir);
  endtask

  typedef struct {
    logic [MSB-1:0] data;
    logic           dir;
    logic [MSB-1:0] stream;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int acc[2];
    int n;
    int low;
    int t;
    logic [MSB-1:0] d;
    logic dir;

    vecs[0] = '{4'b1011, 1'b0, 4'b1011};
    vecs[1] = '{4'b1011, 1'b1, 4'b1101};
    vecs[2] = '{4'b0001, 1'b0, 4'b0001};
    vecs[3] = '{4'b0001, 1'b1, 4'b1000};
    vecs[4] = '{4'b1110, 1'b1, 4'b0111};
    vecs[5] = '{4'b0111, 1'b0, 4'b0111};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
    g_valid = 1'b0; g_data = '0; g_dir = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_en", sr_en, 0);
    check("rst_d", sr_d, 0);
    check("rst_dir", sr_dir, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    #1;
    check("rel_ready", in_ready, 1);

    // Table-driven frames, then idle-state checks after each.
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].data, vecs[i].dir, vecs[i].stream, "vec");
      @(negedge clk);
      check("vec_idle_ready", in_ready, 1);
      check("vec_idle_busy", busy, 0);
      check("vec_dir_hold", sr_dir, vecs[i].dir);
    end

    for (int i = 0; i < 4; i++) begin
      d = MSB'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      send_word(d, dir, dir ? rev(d) : d, "rand");
    end

    // Held valid: back-to-back words 4'hA then 4'h5.
    @(negedge clk);
    @(negedge clk);
    acc[0] = 0; acc[1] = 0; n = 0; low = 0;
    in_valid = 1'b1; in_data = 4'hA; in_dir = 1'b0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      if (in_ready) begin
        acc[n] = cyc;
        exp_q.push_back(exp_word(in_data, in_dir));
        n++;
        @(negedge clk);
        if (n == 1) begin
          in_data = 4'h5; in_dir = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        if (n == 1) low++;
        @(negedge clk);
      end
    end
    check("held_accepts", n, 2);
    check("held_spacing", acc[1] - acc[0], NB + 2);
    check("held_ready_low", low, NB + 1);
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("held_delivered", exp_q.size(), 0);

    // IDLE_GAP=3 instance: in_ready low for exactly 3 cycles after frame_done.
    @(negedge clk);
    g_valid = 1'b1; g_data = 4'h3; g_dir = 1'b0;
    @(negedge clk);
    g_valid = 1'b0;
    t = 0;
    while (!g_frame_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("gap_done", g_frame_done, 1);
    check("gap_ready_in_done", g_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("gap_ready_low", g_ready, 0);
    end
    @(negedge clk);
    check("gap_ready_high", g_ready, 1);

    // Mid-frame reset after the second shift bit.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'hF; in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_en", sr_en, 1);
    rst = 1'b1;
    #1;
    check("arst_en", sr_en, 0);
    check("arst_d", sr_d, 0);
    check("arst_dir", sr_dir, 0);
    check("arst_busy", busy, 0);
    check("arst_done", frame_done, 0);
    check("arst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_no_frame", exp_q.size(), 0);
    send_word(4'h6, 1'b0, 4'b0110, "post_rst");

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
